// File: rtl/wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2m
//
// Purpose:
//   Shares one Wishbone slave port between two masters on the northbridge bus.
//   Master 0 is the LIMB/EC glue and master 1 is the CPU bridge. Ownership is
//   granted round-robin and stays with the owner for as long as it holds cyc.
//   A stall watchdog ends a hung slave cycle by returning err to the owner.
//
// Parameters:
//   ADDR_W   address width on every port
//   DATA_W   data width; byte-select width is DATA_W/8
//   TIMEOUT  number of stalled strobe cycles before an abort; 0 disables it
//
// Ports:
//   clk, rst_n                  clock (posedge) and asynchronous active-low reset
//   m0_* / m1_*                 master-side Wishbone ports (adr, dat, sel, we, stb,
//                               cyc in; dat, ack, err out)
//   s_adr_o .. s_cyc_o          slave-side request, driven by the current owner
//   s_dat_i, s_ack_i, s_err_i   slave response
// -----------------------------------------------------------------------------
module wb_arbiter_2m #(
  parameter int ADDR_W  = 36,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic                m0_we_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,

  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic                m1_we_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,

  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_we_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i
);

  localparam int SEL_W = DATA_W / 8;

  // A zero TIMEOUT would give a zero-width counter; keep one bit so the
  // register stays legal even though it never counts in that case.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Count value seen on the last stalled cycle before the abort fires.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam bit WD_ENABLED = (TIMEOUT > 0);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    OWN0  = 4'b0010,
    OWN1  = 4'b0100,
    ABORT = 4'b1000
  } state_t;

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] wd_count;

  logic own0;
  logic own1;
  logic owning;
  logic aborting;
  logic stalled;
  logic wd_expire;

  assign own0     = (state == OWN0);
  assign own1     = (state == OWN1);
  assign owning   = own0 | own1;
  assign aborting = (state == ABORT);

  // Read data is fanned out to both masters unconditionally; only ack/err
  // qualify it, so there is no need to gate the data path.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Slave-side request mux. The select comes purely from registered state,
  // so no master cyc input can reach the grant combinationally. Outside the
  // owning states the slave sees an all-zero, inactive request.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_stb_o = m0_stb_i;
      s_cyc_o = m0_cyc_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_stb_o = m1_stb_i;
      s_cyc_o = m1_cyc_i;
    end
  end

  // Responses go to the owner only. During ABORT the owner is the master
  // recorded in last, since last is updated on every grant.
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = (own0 & s_err_i) | (aborting & ~last);
  assign m1_err_o = (own1 & s_err_i) | (aborting &  last);

  // A stalled cycle is an owned strobe the slave has not answered. An ack or
  // err on what would be the terminal cycle therefore cancels the abort.
  assign stalled   = owning & s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_expire = WD_ENABLED && stalled && (wd_count == WD_LAST);

  // Stall watchdog: counts consecutive stalled cycles, saturating, and
  // restarts from zero on any non-stalled cycle or outside ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count <= '0;
    end else if (WD_ENABLED && stalled) begin
      if (wd_count != {CNT_W{1'b1}}) begin
        wd_count <= wd_count + CNT_W'(1);
      end
    end else begin
      wd_count <= '0;
    end
  end

  // Arbitration FSM. Owners always return through IDLE, which guarantees a
  // dead cycle between owners. On a tie the master that did not own the bus
  // last wins; last resets to 1 so master 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (last) begin
              state <= OWN0;
              last  <= 1'b0;
            end else begin
              state <= OWN1;
              last  <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            state <= OWN0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= OWN1;
            last  <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            state <= IDLE;
          end else if (wd_expire) begin
            state <= ABORT;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            state <= IDLE;
          end else if (wd_expire) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_2m
//
// Purpose:
//   Directed testbench for wb_arbiter_2m built with TIMEOUT=8. Inputs change
//   one time unit after the rising edge; outputs are sampled on the falling
//   edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_2m;

  localparam int ADDR_W  = 36;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  localparam logic [ADDR_W-1:0] A0 = 36'h0_1234_5678;
  localparam logic [ADDR_W-1:0] A1 = 36'h9_8765_4321;
  localparam logic [DATA_W-1:0] D0 = 32'hDEAD_BEEF;
  localparam logic [DATA_W-1:0] D1 = 32'hCAFE_F00D;

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   m0_adr_i, m1_adr_i;
  logic [DATA_W-1:0]   m0_dat_i, m1_dat_i;
  logic [DATA_W/8-1:0] m0_sel_i, m1_sel_i;
  logic                m0_we_i, m1_we_i;
  logic                m0_stb_i, m1_stb_i;
  logic                m0_cyc_i, m1_cyc_i;
  logic [DATA_W-1:0]   m0_dat_o, m1_dat_o;
  logic                m0_ack_o, m1_ack_o;
  logic                m0_err_o, m1_err_o;
  logic [ADDR_W-1:0]   s_adr_o;
  logic [DATA_W-1:0]   s_dat_o;
  logic [DATA_W/8-1:0] s_sel_o;
  logic                s_we_o, s_stb_o, s_cyc_o;
  logic [DATA_W-1:0]   s_dat_i;
  logic                s_ack_i, s_err_i;

  int checks;
  int errors;
  int prev_owner;
  int exp_owner;

  wb_arbiter_2m #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_we_i  (m0_we_i),
    .m0_stb_i (m0_stb_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_we_i  (m1_we_i),
    .m1_stb_i (m1_stb_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i)
  );

  // 10-unit clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken build can never leave the run hanging.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_m0(input logic active);
    m0_cyc_i = active;
    m0_stb_i = active;
  endtask

  task automatic drive_m1(input logic active);
    m1_cyc_i = active;
    m1_stb_i = active;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_owner = 1;
    exp_owner  = 0;

    rst_n    = 1'b0;
    m0_adr_i = A0;  m0_dat_i = D0;  m0_sel_i = 4'hF;  m0_we_i = 1'b1;
    m1_adr_i = A1;  m1_dat_i = D1;  m1_sel_i = 4'h3;  m1_we_i = 1'b0;
    drive_m0(1'b0);
    drive_m1(1'b0);
    s_dat_i = 32'h5A5A_1234;
    s_ack_i = 1'b1;
    s_err_i = 1'b1;

    // Reset state: slave idle, no responses even with slave ack/err high.
    #2;
    check_output("rst_s_cyc",  s_cyc_o,  0);
    check_output("rst_s_stb",  s_stb_o,  0);
    check_output("rst_s_adr",  s_adr_o,  0);
    check_output("rst_m0_ack", m0_ack_o, 0);
    check_output("rst_m1_ack", m1_ack_o, 0);
    check_output("rst_m0_err", m0_err_o, 0);
    check_output("rst_m1_err", m1_err_o, 0);
    check_output("rst_m0_dat", m0_dat_o, 32'h5A5A_1234);
    check_output("rst_m1_dat", m1_dat_o, 32'h5A5A_1234);
    drive_m0(1'b1);
    drive_m1(1'b1);
    tick();
    check_output("rst_hold_s_cyc", s_cyc_o, 0);
    drive_m0(1'b0);
    drive_m1(1'b0);
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    mid();
    rst_n = 1'b1;

    // Test 1: m0 alone; grant is visible one cycle after cyc is sampled.
    tick();
    drive_m0(1'b1);
    mid();
    check_output("t1_pre_grant_s_cyc", s_cyc_o, 0);
    tick();
    mid();
    check_output("t1_c1_s_cyc", s_cyc_o, 1);
    check_output("t1_c1_s_stb", s_stb_o, 1);
    check_output("t1_c1_s_adr", s_adr_o, A0);
    check_output("t1_c1_s_dat", s_dat_o, D0);
    check_output("t1_c1_s_sel", s_sel_o, 4'hF);
    check_output("t1_c1_s_we",  s_we_o,  1);
    tick();
    mid();
    check_output("t1_c2_s_cyc",  s_cyc_o,  1);
    check_output("t1_c2_m0_ack", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0BAD_F00D;
    mid();
    check_output("t1_c3_m0_ack", m0_ack_o, 1);
    check_output("t1_c3_m1_ack", m1_ack_o, 0);
    check_output("t1_c3_m0_err", m0_err_o, 0);
    check_output("t1_c3_m0_dat", m0_dat_o, 32'h0BAD_F00D);
    tick();
    s_ack_i = 1'b0;
    drive_m0(1'b0);
    mid();
    check_output("t1_drop_s_cyc", s_cyc_o, 0);
    check_output("t1_drop_m0_ack", m0_ack_o, 0);
    tick();
    mid();
    check_output("t1_idle_s_cyc", s_cyc_o, 0);

    // Test 2: fresh reset, simultaneous request goes to m0, then m1 after a gap.
    rst_n = 1'b0;
    mid();
    rst_n = 1'b1;
    tick();
    drive_m0(1'b1);
    drive_m1(1'b1);
    mid();
    check_output("t2_pre_s_cyc", s_cyc_o, 0);
    tick();
    mid();
    check_output("t2_own0_s_cyc", s_cyc_o, 1);
    check_output("t2_own0_s_adr", s_adr_o, A0);
    check_output("t2_own0_s_we",  s_we_o,  1);
    check_output("t2_own0_s_sel", s_sel_o, 4'hF);
    tick();
    s_ack_i = 1'b1;
    mid();
    check_output("t2_own0_m0_ack", m0_ack_o, 1);
    check_output("t2_own0_m1_ack", m1_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    drive_m0(1'b0);
    mid();
    check_output("t2_m0_drop_s_cyc", s_cyc_o, 0);
    tick();
    mid();
    check_output("t2_gap_s_cyc", s_cyc_o, 0);
    check_output("t2_gap_s_adr", s_adr_o, 0);
    tick();
    mid();
    check_output("t2_own1_s_cyc", s_cyc_o, 1);
    check_output("t2_own1_s_adr", s_adr_o, A1);
    check_output("t2_own1_s_we",  s_we_o,  0);
    check_output("t2_own1_s_sel", s_sel_o, 4'h3);
    check_output("t2_own1_s_dat", s_dat_o, D1);
    tick();
    s_ack_i = 1'b1;
    mid();
    check_output("t2_own1_m1_ack", m1_ack_o, 1);
    check_output("t2_own1_m0_ack", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    drive_m1(1'b0);
    mid();
    check_output("t2_m1_drop_s_cyc", s_cyc_o, 0);
    tick();
    mid();
    check_output("t2_end_idle_s_cyc", s_cyc_o, 0);

    // Test 3: both keep requesting; each owner re-raises cyc right after its
    // single-beat cycle. Ownership must alternate, starting with m0.
    tick();
    drive_m0(1'b1);
    drive_m1(1'b1);
    for (int g = 0; g < 8; g++) begin
      exp_owner = (prev_owner == 1) ? 0 : 1;
      tick();
      s_ack_i = 1'b1;
      mid();
      check_output($sformatf("t3_g%0d_s_cyc", g), s_cyc_o, 1);
      check_output($sformatf("t3_g%0d_s_adr", g), s_adr_o, (exp_owner == 1) ? A1 : A0);
      check_output($sformatf("t3_g%0d_m0_ack", g), m0_ack_o, (exp_owner == 0) ? 1 : 0);
      check_output($sformatf("t3_g%0d_m1_ack", g), m1_ack_o, (exp_owner == 1) ? 1 : 0);
      tick();
      s_ack_i = 1'b0;
      if (exp_owner == 0) drive_m0(1'b0);
      else                drive_m1(1'b0);
      mid();
      check_output($sformatf("t3_g%0d_drop_s_cyc", g), s_cyc_o, 0);
      tick();
      if (exp_owner == 0) drive_m0(1'b1);
      else                drive_m1(1'b1);
      mid();
      check_output($sformatf("t3_g%0d_gap_s_cyc", g), s_cyc_o, 0);
      prev_owner = exp_owner;
    end
    tick();
    drive_m0(1'b0);
    drive_m1(1'b0);
    mid();
    tick();
    mid();
    check_output("t3_end_s_cyc", s_cyc_o, 0);

    // Test 4: m1 owns, slave never answers; abort after 8 stalled cycles.
    tick();
    drive_m1(1'b1);
    mid();
    check_output("t4_pre_s_cyc", s_cyc_o, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      mid();
      check_output($sformatf("t4_stall%0d_s_cyc", i), s_cyc_o, 1);
      check_output($sformatf("t4_stall%0d_m1_err", i), m1_err_o, 0);
    end
    tick();
    mid();
    check_output("t4_abort_m1_err", m1_err_o, 1);
    check_output("t4_abort_m1_ack", m1_ack_o, 0);
    check_output("t4_abort_m0_err", m0_err_o, 0);
    check_output("t4_abort_s_cyc",  s_cyc_o,  0);
    check_output("t4_abort_s_stb",  s_stb_o,  0);
    tick();
    mid();
    check_output("t4_idle_m1_err", m1_err_o, 0);
    check_output("t4_idle_s_cyc",  s_cyc_o,  0);
    tick();
    mid();
    check_output("t4_rearb_s_cyc", s_cyc_o, 1);
    check_output("t4_rearb_s_adr", s_adr_o, A1);

    // Test 5: the re-arbitrated cycle is stalled cycle 1; ack on cycle 8
    // must win over the watchdog.
    for (int i = 2; i <= 7; i++) begin
      tick();
      mid();
      check_output($sformatf("t5_stall%0d_s_cyc", i), s_cyc_o, 1);
      check_output($sformatf("t5_stall%0d_m1_err", i), m1_err_o, 0);
    end
    tick();
    s_ack_i = 1'b1;
    mid();
    check_output("t5_c8_m1_ack", m1_ack_o, 1);
    check_output("t5_c8_m1_err", m1_err_o, 0);
    tick();
    s_ack_i = 1'b0;
    mid();
    check_output("t5_c9_s_cyc",  s_cyc_o,  1);
    check_output("t5_c9_m1_err", m1_err_o, 0);
    tick();
    drive_m1(1'b0);
    mid();
    check_output("t5_drop_s_cyc",  s_cyc_o,  0);
    check_output("t5_drop_m1_err", m1_err_o, 0);
    tick();
    mid();
    check_output("t5_idle_s_cyc", s_cyc_o, 0);

    // Test 6: asynchronous reset in the middle of an m0 cycle.
    tick();
    drive_m0(1'b1);
    tick();
    mid();
    check_output("t6_own0_s_cyc", s_cyc_o, 1);
    #1;
    s_ack_i = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_output("t6_rst_s_cyc",  s_cyc_o,  0);
    check_output("t6_rst_s_stb",  s_stb_o,  0);
    check_output("t6_rst_m0_ack", m0_ack_o, 0);
    check_output("t6_rst_m0_err", m0_err_o, 0);
    drive_m1(1'b1);
    tick();
    check_output("t6_rst_hold_s_cyc", s_cyc_o, 0);
    mid();
    rst_n   = 1'b1;
    s_ack_i = 1'b0;
    tick();
    mid();
    check_output("t6_regrant_s_cyc", s_cyc_o, 1);
    check_output("t6_regrant_s_adr", s_adr_o, A0);
    check_output("t6_regrant_s_we",  s_we_o,  1);
    tick();
    drive_m0(1'b0);
    drive_m1(1'b0);
    mid();
    check_output("t6_end_s_cyc", s_cyc_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
